// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS32 pipeline: load-use and mul/div
// stalls, taken-branch flushes and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic        useRs,
  input  logic        useRt,
  input  logic [4:0]  rdEX,
  input  logic        lwEX,
  input  logic        GPRWrEX,
  input  logic        mdStartEX,
  input  logic        mdDivEX,
  input  logic        mdUseID,
  input  logic        branchTaken,
  output logic        PCWr,
  output logic        IFIDWr,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        mdBusy,
  output logic [15:0] stallCount
);

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  md_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_mdCnt, w_mdCnt_nxt;
  logic [15:0]      r_stallCount;

  logic w_loadUse, w_mdPending, w_mdHazard, w_stall;

  assign w_loadUse = lwEX & GPRWrEX & (rdEX != 5'd0) &
                     ((useRs & (rs == rdEX)) | (useRt & (rt == rdEX)));

  assign w_mdPending = (r_state == MD_BUSY) | mdStartEX;
  assign w_mdHazard  = w_mdPending & mdUseID;
  // The ID instruction is on the wrong path when a branch is taken, so never stall it.
  assign w_stall     = ~branchTaken & (w_loadUse | w_mdHazard);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MD_IDLE;
      r_mdCnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mdCnt <= w_mdCnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mdCnt_nxt = r_mdCnt;
    case (r_state)
      MD_IDLE: begin
        if (mdStartEX) begin
          w_mdCnt_nxt = mdDivEX ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          w_state_nxt = MD_BUSY;
        end
      end
      MD_BUSY: begin
        // A start seen here is ignored; the stall logic keeps it from happening.
        w_mdCnt_nxt = r_mdCnt - CNT_W'(1);
        if (r_mdCnt == CNT_W'(1)) w_state_nxt = MD_IDLE;
      end
      default: begin
        w_state_nxt = MD_IDLE;
        w_mdCnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stallCount <= '0;
    else if (w_stall && (r_stallCount != 16'hFFFF))
      r_stallCount <= r_stallCount + 16'd1;
  end

  assign PCWr       = ~w_stall;
  assign IFIDWr     = ~w_stall;
  assign IFIDFlush  = branchTaken;
  assign IDEXFlush  = w_stall | branchTaken;
  assign mdBusy     = (r_state == MD_BUSY);
  assign stallCount = r_stallCount;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed corner cases
// and random traffic against a cycle-count reference model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs, rt, rdEX;
  logic        useRs, useRt, lwEX, GPRWrEX, mdStartEX, mdDivEX, mdUseID, branchTaken;
  logic        PCWr, IFIDWr, IFIDFlush, IDEXFlush, mdBusy;
  logic [15:0] stallCount;

  hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .useRs(useRs), .useRt(useRt),
    .rdEX(rdEX), .lwEX(lwEX), .GPRWrEX(GPRWrEX), .mdStartEX(mdStartEX),
    .mdDivEX(mdDivEX), .mdUseID(mdUseID), .branchTaken(branchTaken),
    .PCWr(PCWr), .IFIDWr(IFIDWr), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
    .mdBusy(mdBusy), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  // Reference model: remaining busy cycles of the mul/div unit and stall total.
  int m_busy = 0;
  int m_cnt  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input bit lw, input bit gpr, input int rd, input int s, input int t,
                       input bit urs, input bit urt, input bit st, input bit dv,
                       input bit mdu, input bit br);
    lwEX = lw; GPRWrEX = gpr; rdEX = 5'(rd); rs = 5'(s); rt = 5'(t);
    useRs = urs; useRt = urt; mdStartEX = st; mdDivEX = dv; mdUseID = mdu; branchTaken = br;
  endtask

  function automatic bit model_stall();
    bit lu;
    lu = lwEX && GPRWrEX && (rdEX != 0) &&
         ((useRs && rs == rdEX) || (useRt && rt == rdEX));
    return !branchTaken && (lu || (((m_busy > 0) || mdStartEX) && mdUseID));
  endfunction

  // One clock: check combinational outputs mid-cycle, advance model, check registered state.
  task automatic tick();
    bit st;
    #2;
    st = model_stall();
    chk("PCWr", int'(PCWr), int'(!st));
    chk("IFIDWr", int'(IFIDWr), int'(!st));
    chk("IFIDFlush", int'(IFIDFlush), int'(branchTaken));
    chk("IDEXFlush", int'(IDEXFlush), int'(st || branchTaken));
    chk("mdBusy", int'(mdBusy), int'(m_busy > 0));
    @(posedge clk);
    if (m_busy > 0) m_busy--;
    else if (mdStartEX) m_busy = mdDivEX ? 32 : 4;
    if (st && m_cnt < 65535) m_cnt++;
    #1;
    chk("stallCount", int'(stallCount), m_cnt);
    chk("mdBusy_post", int'(mdBusy), int'(m_busy > 0));
  endtask

  typedef struct {
    bit lw, gpr; int rd, s, t; bit urs, urt, br;
    bit e_pcwr, e_iff, e_ief;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int s_cnt, b_cnt, s_early, base;

    vecs[0] = '{1,1,8,8,0,1,0,0, 0,0,1};  // rs load-use
    vecs[1] = '{1,1,5,0,5,0,1,0, 0,0,1};  // rt load-use
    vecs[2] = '{1,1,8,8,0,0,0,0, 1,0,0};  // rs not read
    vecs[3] = '{1,1,0,0,0,1,1,0, 1,0,0};  // $zero destination
    vecs[4] = '{1,0,8,8,8,1,1,0, 1,0,0};  // no GPR write
    vecs[5] = '{0,1,8,8,8,1,1,0, 1,0,0};  // not a load
    vecs[6] = '{1,1,8,8,0,1,0,1, 1,1,1};  // branch beats load-use
    vecs[7] = '{0,0,0,0,0,0,0,1, 1,1,1};  // branch alone
    vecs[8] = '{1,1,8,7,9,1,1,0, 1,0,0};  // registers differ

    rst = 1'b1;
    drive(0,0,0,0,0,0,0,0,0,0,0);
    #2;
    chk("rst_PCWr", int'(PCWr), 1);
    chk("rst_IFIDWr", int'(IFIDWr), 1);
    chk("rst_IFIDFlush", int'(IFIDFlush), 0);
    chk("rst_IDEXFlush", int'(IDEXFlush), 0);
    chk("rst_mdBusy", int'(mdBusy), 0);
    chk("rst_stallCount", int'(stallCount), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].lw, vecs[i].gpr, vecs[i].rd, vecs[i].s, vecs[i].t,
            vecs[i].urs, vecs[i].urt, 0, 0, 0, vecs[i].br);
      #1;
      chk($sformatf("vec%0d_PCWr", i), int'(PCWr), int'(vecs[i].e_pcwr));
      chk($sformatf("vec%0d_IFIDFlush", i), int'(IFIDFlush), int'(vecs[i].e_iff));
      chk($sformatf("vec%0d_IDEXFlush", i), int'(IDEXFlush), int'(vecs[i].e_ief));
      tick();
    end

    // Load-use stalls exactly one cycle.
    base = int'(stallCount);
    drive(1,1,8,8,0,1,0,0,0,0,0);
    #1; chk("lu_c0_PCWr", int'(PCWr), 0);
    tick();
    drive(0,1,8,8,0,1,0,0,0,0,0);
    #1; chk("lu_c1_PCWr", int'(PCWr), 1);
    tick();
    chk("lu_delta", int'(stallCount) - base, 1);

    // No false stall.
    base = int'(stallCount);
    drive(1,1,8,8,0,0,0,0,0,0,0); tick();
    drive(1,1,0,0,0,1,0,0,0,0,0); tick();
    chk("nofalse_delta", int'(stallCount) - base, 0);

    // Multiply with a dependent ID instruction.
    base = int'(stallCount); s_cnt = 0; b_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0,0,0,0,0,0,0, i == 0, 0, 1, 0);
      #1;
      if (!PCWr) s_cnt++;
      if (mdBusy) b_cnt++;
      tick();
    end
    chk("mul_stalls", s_cnt, 5);
    chk("mul_busy", b_cnt, 4);
    chk("mul_delta", int'(stallCount) - base, 5);

    // Divide with 10 independent instructions, then a dependent one.
    base = int'(stallCount); s_cnt = 0; b_cnt = 0; s_early = 0;
    for (int i = 0; i < 40; i++) begin
      drive(0,0,0,0,0,0,0, i == 0, 1, i >= 11, 0);
      #1;
      if (!PCWr) begin s_cnt++; if (i < 11) s_early++; end
      if (mdBusy) b_cnt++;
      tick();
    end
    chk("div_early_stalls", s_early, 0);
    chk("div_stalls", s_cnt, 22);
    chk("div_busy", b_cnt, 32);

    // Branch priority over load-use.
    base = int'(stallCount);
    drive(1,1,8,8,0,1,0,0,0,0,1);
    #1;
    chk("br_IFIDFlush", int'(IFIDFlush), 1);
    chk("br_IDEXFlush", int'(IDEXFlush), 1);
    chk("br_PCWr", int'(PCWr), 1);
    tick();
    chk("br_delta", int'(stallCount) - base, 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0,1), $urandom_range(0,3) != 0, $urandom_range(0,3),
            $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,1),
            $urandom_range(0,1), $urandom_range(0,7) == 0, $urandom_range(0,1),
            $urandom_range(0,2) == 0, $urandom_range(0,5) == 0);
      tick();
    end

    // Saturation of the stall counter.
    drive(1,1,8,8,0,1,0,0,0,0,0);
    for (int i = 0; i < 65600; i++) @(posedge clk);
    #1;
    chk("sat_value", int'(stallCount), 65535);
    @(posedge clk); #1;
    chk("sat_hold", int'(stallCount), 65535);
    m_cnt = 65535;
    drive(0,0,0,0,0,0,0,0,0,0,0);
    m_busy = 0;
    tick();

    // Reset in the middle of a divide.
    drive(0,0,0,0,0,0,0,1,1,0,0); tick();
    drive(0,0,0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy_before", int'(mdBusy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_mdBusy", int'(mdBusy), 0);
    chk("mid_rst_stallCount", int'(stallCount), 0);
    m_busy = 0; m_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0,0,0,0,0,0,0,0,0,1,0);
    #1;
    chk("post_rst_PCWr", int'(PCWr), 1);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS32 datapath; it sits beside the forwarding unit and covers the hazards forwarding cannot resolve. It stalls the front end on load-use dependences and on HI/LO accesses while the multi-cycle multiply/divide unit is busy. It flushes wrong-path instructions on taken branches. It also keeps a saturating stall-cycle counter for performance analysis.

## Interface
- `MULT_CYCLES`, default 4: busy cycles after a multiply starts.
- `DIV_CYCLES`, default 32: busy cycles after a divide starts.
- `CNT_W`, default 6: width of the mul/div countdown; must hold `DIV_CYCLES`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `rs`, `rt` input 5 each: source registers of the instruction in ID.
- `useRs`, `useRt` input 1 each: ID instruction actually reads `rs`/`rt`.
- `rdEX` input 5: destination register of the EX instruction.
- `lwEX` input 1: EX instruction is a load.
- `GPRWrEX` input 1: EX instruction writes the GPR file.
- `mdStartEX` input 1: EX instruction is mult/multu/div/divu.
- `mdDivEX` input 1: qualifies `mdStartEX`; 1 = divide, 0 = multiply.
- `mdUseID` input 1: ID instruction is mfhi/mflo/mthi/mtlo or a mul/div.
- `branchTaken` input 1: EX branch/jump resolved taken this cycle.
- `PCWr` output 1: PC write enable.
- `IFIDWr` output 1: IF/ID register write enable.
- `IFIDFlush` output 1: clear IF/ID to a bubble.
- `IDEXFlush` output 1: insert a bubble into ID/EX.
- `mdBusy` output 1: mul/div unit is still computing.
- `stallCount` output 16: saturating count of stall cycles.

## Operation
- **Load-use hazard** (combinational): `loadUse = lwEX & GPRWrEX & (rdEX != 0) & ((useRs & rs == rdEX) | (useRt & rt == rdEX))`.
- **Mul/div FSM**, with states MD_IDLE and MD_BUSY and a countdown `mdCnt` of `CNT_W` bits.
  - MD_IDLE with `mdStartEX`: load `mdCnt` = `mdDivEX` ? `DIV_CYCLES` : `MULT_CYCLES`, then go to MD_BUSY.
  - MD_BUSY: decrement `mdCnt` each cycle. When `mdCnt` = 1, go to MD_IDLE at the next edge and `mdCnt` becomes 0.
  - `mdStartEX` arriving in MD_BUSY is ignored: the count is not reloaded and the state is not changed. The stall logic prevents this case from arising.
- **Pending and mul/div hazard:**
  - `mdPending = (state == MD_BUSY) | mdStartEX`.
  - `mdHazard = mdPending & mdUseID`.
- **Stall:** `stall = ~branchTaken & (loadUse | mdHazard)`. A taken branch has priority because the ID instruction is on the wrong path.
- **Outputs:**
  - `PCWr = IFIDWr = ~stall`.
  - `IFIDFlush = branchTaken`.
  - `IDEXFlush = stall | branchTaken`.
  - `mdBusy = (state == MD_BUSY)`.
- **stallCount:** increments by 1 at each edge where `stall` = 1, and saturates at 16'hFFFF.

## Timing
- Reset values: state MD_IDLE, `mdCnt` 0, `stallCount` 0.
- Outputs during reset, with all inputs at 0: `PCWr`/`IFIDWr` = 1, flushes 0, `mdBusy` 0.
- Reset acts mid-operation with the same effect: an in-flight mul/div count is discarded immediately.
- `PCWr`, `IFIDWr`, `IFIDFlush` and `IDEXFlush` are combinational from the current inputs and state, with zero latency. They must settle within the same cycle.
- A load-use stall lasts exactly 1 cycle. Next cycle the load is in MEM, `lwEX` is 0, and forwarding supplies `outMEM`.
- A mul/div dependence where `mdUseID` is asserted in the cycle `mdStartEX` = 1 stalls for N+1 cycles: the start cycle plus N busy cycles. N is `MULT_CYCLES` or `DIV_CYCLES`.
- An unrelated ID instruction (`mdUseID` = 0) never stalls while `mdBusy` = 1.
- When `loadUse` and `mdHazard` coincide, there is a single stall and `stallCount` increments once.
- The loads `rdEX` = 0 and `GPRWrEX` = 0 never stall.

## Test plan
- **Load-use:** `lwEX` = 1, `GPRWrEX` = 1, `rdEX` = 8, `rs` = 8, `useRs` = 1, then `lwEX` = 0 the next cycle.
  - Cycle 0: `PCWr` = 0, `IFIDWr` = 0, `IDEXFlush` = 1.
  - Cycle 1: `PCWr` = 1.
  - `stallCount` = 1.
- **No false stall:**
  - Same as the load-use case but `useRs` = 0, giving `PCWr` = 1.
  - Repeat with `rdEX` = 0, `rs` = 0, `useRs` = 1, giving `PCWr` = 1.
  - `stallCount` stays 0 in both.
- **Multiply wait:** `mdStartEX` = 1, `mdDivEX` = 0, `mdUseID` held 1.
  - `PCWr` = 0 for 5 cycles, then 1.
  - `mdBusy` = 1 for exactly 4 cycles.
  - `stallCount` = 5.
- **Divide with independent traffic:** `mdStartEX` = 1, `mdDivEX` = 1, then `mdUseID` = 0 for 10 cycles, then 1.
  - No stall while `mdUseID` = 0.
  - Stall for the remaining 22 busy cycles; `mdBusy` drops 32 cycles after the start.
- **Branch priority:** `branchTaken` = 1 with a `loadUse` condition in the same cycle.
  - `IFIDFlush` = 1, `IDEXFlush` = 1, `PCWr` = 1.
  - `stallCount` is unchanged.
- **Reset mid-divide:** assert `rst` 10 cycles after a divide start.
  - `mdBusy` = 0 and `stallCount` = 0 immediately, without waiting for a clock edge.
  - After `rst` is released with `mdUseID` = 1, no stall occurs.
